// File: rtl/i2s_codec_ctrl.sv
// I2S codec controller: divides clk into m/b/LR clocks, serialises DAC pairs, captures ADC pairs.
// Define I2S_CODEC_I2S_DELAY_EN for Philips I2S timing; the default build is left-justified.
module i2s_codec_ctrl #(
    parameter int unsigned M_DVSR   = 2,
    parameter int unsigned B_DVSR   = 3,
    parameter int unsigned SLOT_W   = 16,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] dac_left,
    input  logic [SAMPLE_W-1:0] dac_right,
    input  logic                dac_valid,
    output logic                dac_ready,
    output logic [SAMPLE_W-1:0] adc_left,
    output logic [SAMPLE_W-1:0] adc_right,
    output logic                adc_valid,
    input  logic                adc_ready,
    output logic                dac_underrun,
    output logic                adc_overrun,
    input  logic                clr_flags,
    output logic                m_clk,
    output logic                b_clk,
    output logic                dac_lr_clk,
    output logic                adc_lr_clk,
    output logic                dacdat,
    input  logic                adcdat,
    output logic                frame_tick
);

    localparam int unsigned FRAME_W = 2 * SLOT_W;
    localparam int unsigned SLOT_CW = $clog2(FRAME_W);
    localparam logic [SLOT_CW-1:0] LAST_SLOT = SLOT_CW'(FRAME_W - 1);
    localparam logic [SLOT_CW-1:0] RIGHT_SLOT = SLOT_CW'(SLOT_W);

    logic [M_DVSR-1:0]   m_cnt_q;
    logic [B_DVSR-1:0]   b_cnt_q;
    logic                b_clk_prev_q;
    logic [SLOT_CW-1:0]  slot_q;
    logic [FRAME_W-1:0]  dac_sh_q;
    logic [FRAME_W-1:0]  adc_sh_q;
    logic                hold_full_q;
    logic [SAMPLE_W-1:0] hold_left_q;
    logic [SAMPLE_W-1:0] hold_right_q;
    logic [SAMPLE_W-1:0] adc_left_q;
    logic [SAMPLE_W-1:0] adc_right_q;
    logic                adc_valid_q;
    logic                underrun_q;
    logic                overrun_q;

    logic                b_fall;
    logic                b_rise;
    logic                load_ev;
    logic                capture_ev;
    logic                dac_xfer;
    logic [SLOT_W-1:0]   left_slot;
    logic [SLOT_W-1:0]   right_slot;
    logic [FRAME_W-1:0]  load_word;

    assign b_clk    = b_cnt_q[B_DVSR-1];
    assign b_fall   = b_clk_prev_q & ~b_clk & ~rst;
    assign b_rise   = ~b_clk_prev_q & b_clk & ~rst;
    assign load_ev  = b_fall & (slot_q == LAST_SLOT);
    assign dac_xfer = dac_valid & dac_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_cnt_q      <= '0;
            b_cnt_q      <= '0;
            b_clk_prev_q <= 1'b0;
            slot_q       <= '0;
        end else begin
            m_cnt_q      <= m_cnt_q + M_DVSR'(1);
            b_clk_prev_q <= b_clk;
            if (m_cnt_q == '0) begin
                b_cnt_q <= b_cnt_q + B_DVSR'(1);
            end
            if (b_fall) begin
                slot_q <= (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_CW'(1);
            end
        end
    end

    // Held pair wins; otherwise a pair offered exactly at the load goes straight in, else silence.
    always_comb begin
        left_slot  = '0;
        right_slot = '0;
        left_slot[SLOT_W-1 -: SAMPLE_W]  = hold_full_q ? hold_left_q : dac_left;
        right_slot[SLOT_W-1 -: SAMPLE_W] = hold_full_q ? hold_right_q : dac_right;
        load_word = {left_slot, right_slot};
        if (!hold_full_q && !dac_valid) begin
            load_word = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_sh_q     <= '0;
            hold_full_q  <= 1'b0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
        end else begin
            if (load_ev) begin
                dac_sh_q <= load_word;
            end else if (b_fall) begin
                dac_sh_q <= {dac_sh_q[FRAME_W-2:0], 1'b0};
            end
            if (load_ev) begin
                hold_full_q <= 1'b0;
            end else if (dac_xfer) begin
                hold_full_q  <= 1'b1;
                hold_left_q  <= dac_left;
                hold_right_q <= dac_right;
            end
        end
    end

`ifdef I2S_CODEC_I2S_DELAY_EN
    logic dac_dly_q;
    logic load_seen_q;

    // Data trails LR by one bclk, so capture waits one bclk past the load.
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_dly_q   <= 1'b0;
            load_seen_q <= 1'b0;
        end else if (b_fall) begin
            dac_dly_q   <= dac_sh_q[FRAME_W-1];
            load_seen_q <= load_ev;
        end
    end

    assign dacdat     = dac_dly_q;
    assign capture_ev = b_fall & load_seen_q;
`else
    assign dacdat     = dac_sh_q[FRAME_W-1];
    assign capture_ev = load_ev;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            adc_sh_q    <= '0;
            adc_left_q  <= '0;
            adc_right_q <= '0;
            adc_valid_q <= 1'b0;
        end else begin
            if (b_rise) begin
                adc_sh_q <= {adc_sh_q[FRAME_W-2:0], adcdat};
            end
            if (capture_ev) begin
                adc_left_q  <= adc_sh_q[FRAME_W-1 -: SAMPLE_W];
                adc_right_q <= adc_sh_q[SLOT_W-1 -: SAMPLE_W];
                adc_valid_q <= 1'b1;
            end else if (adc_valid_q && adc_ready) begin
                adc_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (load_ev && !hold_full_q && !dac_valid) begin
                underrun_q <= 1'b1;
            end else if (clr_flags) begin
                underrun_q <= 1'b0;
            end
            if (capture_ev && adc_valid_q && !adc_ready) begin
                overrun_q <= 1'b1;
            end else if (clr_flags) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign m_clk        = m_cnt_q[M_DVSR-1];
    assign dac_lr_clk   = (slot_q >= RIGHT_SLOT);
    assign adc_lr_clk   = dac_lr_clk;
    assign frame_tick   = load_ev;
    assign dac_ready    = ~hold_full_q;
    assign adc_left     = adc_left_q;
    assign adc_right    = adc_right_q;
    assign adc_valid    = adc_valid_q;
    assign dac_underrun = underrun_q;
    assign adc_overrun  = overrun_q;

endmodule

// File: tb/tb_i2s_codec_ctrl.sv
// Bench for i2s_codec_ctrl: directed scenarios plus random traffic against a frame-level model.
module tb_i2s_codec_ctrl;

`ifdef I2S_CODEC_I2S_DELAY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dac_left, dac_right, adc_left, adc_right;
    logic        dac_valid, dac_ready, adc_valid, adc_ready;
    logic        dac_underrun, adc_overrun, clr_flags;
    logic        m_clk, b_clk, dac_lr_clk, adc_lr_clk, dacdat, adcdat, frame_tick;
    logic        loop, adc_rand;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign adcdat = loop ? dacdat : adc_rand;

    i2s_codec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .dac_left    (dac_left),
        .dac_right   (dac_right),
        .dac_valid   (dac_valid),
        .dac_ready   (dac_ready),
        .adc_left    (adc_left),
        .adc_right   (adc_right),
        .adc_valid   (adc_valid),
        .adc_ready   (adc_ready),
        .dac_underrun(dac_underrun),
        .adc_overrun (adc_overrun),
        .clr_flags   (clr_flags),
        .m_clk       (m_clk),
        .b_clk       (b_clk),
        .dac_lr_clk  (dac_lr_clk),
        .adc_lr_clk  (adc_lr_clk),
        .dacdat      (dacdat),
        .adcdat      (adcdat),
        .frame_tick  (frame_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bclk = 32 clk, frame = 32 bclk; frame j is shown after load fall 32*j.
    int          n;
    int          rst_cyc = 0;
    logic [31:0] frames [64];
    logic [31:0] hold_q [$];
    logic [31:0] cap_buf;
    logic        m_valid, m_under, m_over;
    logic [15:0] m_left, m_right;

    function automatic logic exp_dac(input int cyc);
        int pos;
        pos = (cyc + 2) / 32 - DLY;
        if (pos < 0 || pos / 32 >= 64) return 1'b0;
        return frames[pos / 32][31 - pos % 32];
    endfunction

    always @(negedge clk) begin : monitor
        int          fe, f, p;
        logic        e_dac, fall, cap, load, set_u, set_o;
        logic [31:0] w;
        if (rst) begin
            if (rst_cyc > 0) begin
                check("rst_outs", 32'({m_clk, b_clk, dac_lr_clk, adc_lr_clk, dacdat, frame_tick,
                                       adc_valid, dac_underrun, adc_overrun, dac_ready}), 32'h1);
                check("rst_adc_data", {adc_left, adc_right}, 32'h0);
            end
            rst_cyc++;
            n = 0;
            foreach (frames[i]) frames[i] = '0;
            hold_q.delete();
            cap_buf = '0;
            m_valid = 0; m_under = 0; m_over = 0; m_left = '0; m_right = '0;
        end else begin
            rst_cyc = 0;
            fe    = (n + 2) / 32;
            e_dac = exp_dac(n);
            check("m_clk", 32'(m_clk), 32'((n % 4) >= 2));
            check("b_clk", 32'(b_clk), 32'((((n + 3) / 4) % 8) >= 4));
            check("lr_clk", 32'({dac_lr_clk, adc_lr_clk}), {30'b0, {2{(fe % 32) >= 16}}});
            check("dacdat", 32'(dacdat), 32'(e_dac));
            check("frame_tick", 32'(frame_tick), 32'((n + 3) % 1024 == 0));
            check("dac_ready", 32'(dac_ready), 32'(hold_q.size() == 0));
            check("adc_valid", 32'(adc_valid), 32'(m_valid));
            check("flags", 32'({dac_underrun, adc_overrun}), 32'({m_under, m_over}));
            if (m_valid) check("adc_data", {adc_left, adc_right}, {m_left, m_right});

            if (n >= 13 && (n - 13) % 32 == 0) begin
                p = (n - 13) / 32 - DLY;
                if (p >= 0) cap_buf[31 - p % 32] = loop ? e_dac : adc_rand;
            end
            fall  = (n >= 29) && ((n + 3) % 32 == 0);
            f     = (n + 3) / 32;
            load  = fall && (f % 32 == 0);
            cap   = fall && (f >= 32 + DLY) && ((f - DLY) % 32 == 0);
            set_u = 0;
            set_o = 0;
            if (cap) begin
                if (m_valid && !adc_ready) set_o = 1;
                m_valid = 1;
                m_left  = cap_buf[31:16];
                m_right = cap_buf[15:0];
            end else if (m_valid && adc_ready) begin
                m_valid = 0;
            end
            if (load) begin
                if (hold_q.size() > 0) w = hold_q.pop_front();
                else if (dac_valid) w = {dac_left, dac_right};
                else begin
                    w = '0;
                    set_u = 1;
                end
                if (f / 32 < 64) frames[f / 32] = w;
            end else if (dac_valid && hold_q.size() == 0) begin
                hold_q.push_back({dac_left, dac_right});
            end
            m_under = set_u ? 1'b1 : (clr_flags ? 1'b0 : m_under);
            m_over  = set_o ? 1'b1 : (clr_flags ? 1'b0 : m_over);
            n++;
        end
    end

    task automatic wait_tick(input string tag);
        for (int t = 0; t < 2100; t++) begin
            @(negedge clk);
            if (frame_tick) break;
        end
        check(tag, 32'(frame_tick), 32'h1);
    endtask

    task automatic wait_lr_fall(input string tag);
        logic prev;
        prev = dac_lr_clk;
        for (int t = 0; t < 2100; t++) begin
            @(negedge clk);
            if (prev && !dac_lr_clk) break;
            prev = dac_lr_clk;
        end
        check(tag, 32'(prev && !dac_lr_clk), 32'h1);
    endtask

    // One sample per bclk, mid-bit; first sample taken 'first' negedges from now.
    task automatic grab_frame(input int first, output logic [31:0] bits);
        for (int i = 0; i < 32; i++) begin
            repeat ((i == 0) ? first : 32) @(negedge clk);
            bits[31 - i] = dacdat;
        end
    endtask

    task automatic write_pair(input logic [15:0] l, input logic [15:0] r);
        @(posedge clk); #1;
        dac_valid = 1; dac_left = l; dac_right = r;
        @(posedge clk); #1;
        dac_valid = 0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_flags = 1;
        @(posedge clk); #1 clr_flags = 0;
    endtask

    logic [31:0] bits;

    initial begin
        rst = 1; dac_valid = 0; dac_left = '0; dac_right = '0;
        adc_ready = 1; clr_flags = 0; loop = 1; adc_rand = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_clocks", 32'({m_clk, b_clk, dac_lr_clk, adc_lr_clk, dacdat, adc_valid}), 32'h0);
        check("reset_ready", 32'(dac_ready), 32'h1);
        @(posedge clk); #1 rst = 0;

        // Frame 1: nothing written -> silence and underrun
        wait_tick("tick1");
        grab_frame(16, bits);
        check("underrun_bits", bits, 32'h0);
        check("underrun_flag", 32'(dac_underrun), 32'h1);
        write_pair(16'hA5F0, 16'h0F0F);
        @(negedge clk);
        check("ready_after_write", 32'(dac_ready), 32'h0);
        check("underrun_held", 32'(dac_underrun), 32'h1);
        pulse_clr();
        @(negedge clk);
        check("underrun_cleared", 32'(dac_underrun), 32'h0);

        // Frame 2: playback
        wait_tick("tick2");
        @(negedge clk);
        check("ready_at_tick", 32'(dac_ready), 32'h1);
        grab_frame(15, bits);
        check("playback_bits", bits, (DLY != 0) ? 32'h52F8_0787 : 32'hA5F0_0F0F);
        write_pair(16'h1234, 16'hFEDC);
        adc_ready = 0;

        // Frame 3: loopback of 1234/FEDC; frame 2 already captured
        wait_tick("tick3");
        grab_frame(16, bits);
        check("loop_tx_bits", bits, (DLY != 0) ? 32'h891A_7F6E : 32'h1234_FEDC);
        check("capture_a5f0", {adc_left, adc_right}, 32'hA5F0_0F0F);
        check("capture_valid", 32'(adc_valid), 32'h1);
        check("no_overrun_yet", 32'(adc_overrun), 32'h0);

        // Frame 4: second capture without adc_ready -> overrun, latest data kept
        wait_tick("tick4");
        grab_frame(16, bits);
        check("underrun2_bits", bits, 32'h0);
        check("loopback_data", {adc_left, adc_right}, 32'h1234_FEDC);
        check("overrun_flag", 32'(adc_overrun), 32'h1);
        repeat (3) @(negedge clk);
        check("valid_held", 32'(adc_valid), 32'h1);
        @(posedge clk); #1 adc_ready = 1;
        @(posedge clk); #1 adc_ready = 0;
        @(negedge clk);
        check("valid_cleared", 32'(adc_valid), 32'h0);
        write_pair(16'h8000, 16'h0000);
        pulse_clr();
        @(negedge clk);
        check("flags_cleared", 32'({dac_underrun, adc_overrun}), 32'h0);

        // Frame 5: MSB position relative to the LR fall
        wait_lr_fall("lr_fall5");
        repeat (15) @(negedge clk);
        bits[1] = dacdat;
        repeat (32) @(negedge clk);
        bits[0] = dacdat;
        check("msb_position", 32'(bits[1:0]), (DLY != 0) ? 32'h1 : 32'h2);

        // Frame 7: pair offered exactly on the load with the holding register empty
        wait_tick("tick6");
        repeat (512) @(posedge clk);
        #1 clr_flags = 1;
        repeat (512) @(posedge clk);
        #1 clr_flags = 0; dac_valid = 1; dac_left = 16'h5A5A; dac_right = 16'hC3C3;
        @(posedge clk); #1 dac_valid = 0;
        @(negedge clk);
        check("direct_no_underrun", 32'(dac_underrun), 32'h0);
        grab_frame(15, bits);
        check("direct_bits", bits, (DLY != 0) ? 32'h2D2D_61E1 : 32'h5A5A_C3C3);

        // Random traffic, then a mid-frame reset and more traffic
        for (int c = 0; c < 8 * 1024; c++) begin
            @(posedge clk); #1;
            if (c % 1024 == 0) loop = 1'($urandom_range(0, 1));
            adc_rand  = 1'($urandom);
            adc_ready = ($urandom_range(0, 3) != 0);
            clr_flags = ($urandom_range(0, 63) == 0);
            dac_valid = ($urandom_range(0, 299) == 0);
            dac_left  = 16'($urandom);
            dac_right = 16'($urandom);
        end
        #0;
        rst = 1; dac_valid = 0; clr_flags = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        for (int c = 0; c < 3 * 1024; c++) begin
            @(posedge clk); #1;
            adc_rand  = 1'($urandom);
            adc_ready = ($urandom_range(0, 1) != 0);
            clr_flags = ($urandom_range(0, 127) == 0);
            dac_valid = ($urandom_range(0, 199) == 0);
            dac_left  = 16'($urandom);
            dac_right = 16'($urandom);
            if (c == 1500) begin
                rst = 1;
                repeat (3) @(posedge clk);
                #1 rst = 0;
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
